fp_operand_loader: RTL and testbench

Byte-serial front/back end for the combinational floating-point add/subtract unit. It collects two IEEE 754 single-precision operands from an 8-bit input stream, holds them and the operation bit stable on the adder inputs, captures the adder result, and streams the result back out one byte at a time. This stage is what lets the 32-bit datapath run behind an 8-bit pin interface.

---
 rtl/fp_operand_loader_pkg.sv | 15 +
 rtl/fp_operand_loader_if.sv | 25 ++
 rtl/fp_operand_loader_byte_serializer.sv | 28 ++
 rtl/fp_operand_loader.sv | 74 +++++++
 tb/tb_fp_operand_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_operand_loader_pkg.sv
// fp_operand_loader_pkg: shared widths, state encoding and byte-lane helper
package fp_operand_loader_pkg;
    localparam int FP_W = 32;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        UNLOAD = 2'd3
    } state_t;
    // byte index to 32-bit lane; MSB-first order simply reverses the lanes
    function automatic logic [1:0] lane_sel(input logic [1:0] idx, input bit lsb_first);
        return lsb_first ? idx : ~idx;
    endfunction
endpackage

// File: rtl/fp_operand_loader_if.sv
// fp_operand_loader_if: byte streams, adder-side operands and status of the loader
interface fp_operand_loader_if;
    import fp_operand_loader_pkg::*;
    logic              clear;
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_sub;
    logic [FP_W-1:0]   a_out;
    logic [FP_W-1:0]   b_out;
    logic              sub_out;
    logic [FP_W-1:0]   result_in;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    modport slave (
        input  clear, in_data, in_valid, in_sub, result_in, out_ready,
        output in_ready, a_out, b_out, sub_out, out_data, out_valid, busy
    );
    modport master (
        output clear, in_data, in_valid, in_sub, result_in, out_ready,
        input  in_ready, a_out, b_out, sub_out, out_data, out_valid, busy
    );
endinterface

// File: rtl/fp_operand_loader_byte_serializer.sv
// fp_operand_loader_byte_serializer: result register, lane mux and output handshake
module fp_operand_loader_byte_serializer
    import fp_operand_loader_pkg::*;
#(
    parameter bit LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_active,
    input  logic              i_ready,
    input  logic [1:0]        i_idx,
    input  logic [FP_W-1:0]   i_result,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_xfer
);
    logic [FP_W-1:0] r_result;
    logic [4:0]      w_bit;
    always_ff @(posedge clk) begin
        if (rst) r_result <= '0;
        else if (i_capture) r_result <= i_result;
    end
    assign w_bit   = {lane_sel(i_idx, LSB_FIRST), 3'b000};
    assign o_valid = i_active;
    assign o_data  = i_active ? r_result[w_bit +: BYTE_W] : '0;
    assign o_xfer  = i_active && i_ready;
endmodule

// File: rtl/fp_operand_loader.sv
// fp_operand_loader: byte-serial operand collector and result streamer for the FP add/sub unit
module fp_operand_loader
    import fp_operand_loader_pkg::*;
#(
    parameter bit LSB_FIRST = 1
) (
    input logic                clk,
    input logic                rst,
    fp_operand_loader_if.slave bus
);
    state_t          r_state;
    logic [1:0]      r_idx;
    logic [FP_W-1:0] r_a;
    logic [FP_W-1:0] r_b;
    logic            r_sub;
    logic            w_accept;
    logic            w_xfer;
    logic            w_last;
    logic [4:0]      w_bit;
    assign bus.in_ready = r_state == LOAD_A || r_state == LOAD_B;
    assign bus.busy     = r_state == EXEC || r_state == UNLOAD;
    assign bus.a_out    = r_a;
    assign bus.b_out    = r_b;
    assign bus.sub_out  = r_sub;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_last       = r_idx == 2'd3;
    assign w_bit        = {lane_sel(r_idx, LSB_FIRST), 3'b000};
    // every phase change happens at idx 3, so the wrapping increment also clears the index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_A;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
        end else if (bus.clear) begin
            r_state <= LOAD_A;
            r_idx   <= '0;
        end else begin
            case (r_state)
                LOAD_A: if (w_accept) begin
                    r_a[w_bit +: BYTE_W] <= bus.in_data;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_state <= LOAD_B;
                end
                LOAD_B: if (w_accept) begin
                    r_b[w_bit +: BYTE_W] <= bus.in_data;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sub   <= bus.in_sub;
                        r_state <= EXEC;
                    end
                end
                EXEC: r_state <= UNLOAD;
                UNLOAD: if (w_xfer) begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_state <= LOAD_A;
                end
            endcase
        end
    end
    fp_operand_loader_byte_serializer #(.LSB_FIRST(LSB_FIRST)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .i_capture (r_state == EXEC && !bus.clear),
        .i_active  (r_state == UNLOAD),
        .i_ready   (bus.out_ready),
        .i_idx     (r_idx),
        .i_result  (bus.result_in),
        .o_data    (bus.out_data),
        .o_valid   (bus.out_valid),
        .o_xfer    (w_xfer)
    );
endmodule

// File: tb/tb_fp_operand_loader.sv
// tb_fp_operand_loader: scoreboard bench, LSB-first and MSB-first instances with a table-driven adder stand-in
module tb_fp_operand_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] uq[$];
    logic [7:0] gq[$];
    always #5 clk = ~clk;
    fp_operand_loader_if u_if();
    fp_operand_loader_if g_if();
    fp_operand_loader #(.LSB_FIRST(1)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
    fp_operand_loader #(.LSB_FIRST(0)) g_dut (.clk(clk), .rst(rst), .bus(g_if));
    // hand-computed single-precision sums for the vectors used below
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
        case ({s, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
            {1'b0, 32'h3F812345, 32'h3F812345}: return 32'h40012345;
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
            default: return 32'hDEADBEEF;
        endcase
    endfunction
    assign u_if.result_in = fadd(u_if.a_out, u_if.b_out, u_if.sub_out);
    assign g_if.result_in = fadd(g_if.a_out, g_if.b_out, g_if.sub_out);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic send_u(input logic [7:0] d, input logic s);
        u_if.in_data = d;
        u_if.in_sub = s;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        #1 u_if.in_valid = 1'b0;
    endtask
    task automatic frame_u(input logic [31:0] a, input logic [31:0] b, input logic s);
        for (int i = 0; i < 4; i++) send_u(a[8*i +: 8], !s);
        for (int i = 0; i < 4; i++) send_u(b[8*i +: 8], i == 3 ? s : !s);
    endtask
    task automatic push_u(input logic [31:0] r);
        for (int i = 0; i < 4; i++) uq.push_back(r[8*i +: 8]);
    endtask
    task automatic wait_idle_u();
        int n = 0;
        while (!u_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("u_idle", {31'b0, u_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask
    task automatic send_g(input logic [7:0] d);
        g_if.in_data = d;
        g_if.in_sub = 1'b0;
        g_if.in_valid = 1'b1;
        @(posedge clk);
        #1 g_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (u_if.out_valid && u_if.out_ready && !u_if.clear && !rst) begin
            if (uq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u_byte: got %h, expected no byte", u_if.out_data);
            end else chk("u_byte", {24'b0, u_if.out_data}, {24'b0, uq.pop_front()});
        end
        if (g_if.out_valid && g_if.out_ready && !g_if.clear && !rst) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL g_byte: got %h, expected no byte", g_if.out_data);
            end else chk("g_byte", {24'b0, g_if.out_data}, {24'b0, gq.pop_front()});
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        u_if.clear = 0; u_if.in_valid = 0; u_if.in_data = 0; u_if.in_sub = 0; u_if.out_ready = 1;
        g_if.clear = 0; g_if.in_valid = 0; g_if.in_data = 0; g_if.in_sub = 0; g_if.out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, u_if.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, u_if.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, u_if.busy}, 32'd0);
        chk("rst_out_data", {24'b0, u_if.out_data}, 32'd0);
        chk("rst_a", u_if.a_out, 32'd0);
        chk("rst_b", u_if.b_out, 32'd0);
        chk("rst_sub", {31'b0, u_if.sub_out}, 32'd0);
        @(posedge clk);
        #1;
        // add: 1.0 + 2.0, sub bit high on all but the 8th byte
        push_u(32'h40400000);
        frame_u(32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        chk("add_a", u_if.a_out, 32'h3F800000);
        chk("add_b", u_if.b_out, 32'h40000000);
        chk("add_sub", {31'b0, u_if.sub_out}, 32'd0);
        chk("exec_busy", {31'b0, u_if.busy}, 32'd1);
        chk("exec_out_valid", {31'b0, u_if.out_valid}, 32'd0);
        @(negedge clk);
        chk("add_latency", {31'b0, u_if.out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        chk("add_last_in_ready", {31'b0, u_if.in_ready}, 32'd0);
        @(negedge clk);
        chk("add_b2b_in_ready", {31'b0, u_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // subtract: 3.0 - 1.0
        push_u(32'h40000000);
        frame_u(32'h40400000, 32'h3F800000, 1'b1);
        @(negedge clk);
        chk("sub_exec", {31'b0, u_if.sub_out}, 32'd1);
        @(negedge clk);
        chk("sub_unload", {31'b0, u_if.sub_out}, 32'd1);
        wait_idle_u();
        // backpressure at byte 1
        push_u(32'h40012345);
        frame_u(32'h3F812345, 32'h3F812345, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 u_if.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", {24'b0, u_if.out_data}, 32'h23);
            chk("bp_valid", {31'b0, u_if.out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 u_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_last_in_ready", {31'b0, u_if.in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_done_in_ready", {31'b0, u_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // reset after 5 accepted bytes
        send_u(8'h11, 1'b1);
        send_u(8'h22, 1'b1);
        send_u(8'h33, 1'b1);
        send_u(8'h44, 1'b1);
        send_u(8'h55, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'b0, u_if.in_ready}, 32'd1);
        chk("mid_rst_busy", {31'b0, u_if.busy}, 32'd0);
        chk("mid_rst_a", u_if.a_out, 32'd0);
        chk("mid_rst_b", u_if.b_out, 32'd0);
        chk("mid_rst_sub", {31'b0, u_if.sub_out}, 32'd0);
        @(posedge clk);
        #1;
        push_u(32'h40800000);
        frame_u(32'h40000000, 32'h40000000, 1'b0);
        @(negedge clk);
        chk("fresh_a", u_if.a_out, 32'h40000000);
        chk("fresh_b", u_if.b_out, 32'h40000000);
        wait_idle_u();
        // clear coinciding with a transfer in UNLOAD
        u_if.out_ready = 1'b0;
        frame_u(32'h3F800000, 32'h40000000, 1'b0);
        @(posedge clk);
        #1;
        u_if.clear = 1'b1;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        chk("clr_in_unload", {31'b0, u_if.out_valid}, 32'd1);
        @(posedge clk);
        #1 u_if.clear = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", {31'b0, u_if.out_valid}, 32'd0);
        chk("clr_in_ready", {31'b0, u_if.in_ready}, 32'd1);
        chk("clr_a_kept", u_if.a_out, 32'h3F800000);
        chk("clr_b_kept", u_if.b_out, 32'h40000000);
        @(posedge clk);
        #1;
        push_u(32'h40012345);
        frame_u(32'h3F812345, 32'h3F812345, 1'b0);
        wait_idle_u();
        // MSB-first instance with a gap after every byte
        gq.push_back(8'h40);
        gq.push_back(8'h40);
        gq.push_back(8'h00);
        gq.push_back(8'h00);
        send_g(8'h3F); send_g(8'h80); send_g(8'h00); send_g(8'h00);
        send_g(8'h40); send_g(8'h00); send_g(8'h00); send_g(8'h00);
        @(negedge clk);
        chk("gap_a", g_if.a_out, 32'h3F800000);
        chk("gap_b", g_if.b_out, 32'h40000000);
        begin
            int n = 0;
            while (!g_if.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("g_idle", {31'b0, g_if.in_ready}, 32'd1);
        end
        @(negedge clk);
        chk("u_drained", uq.size(), 32'd0);
        chk("g_drained", gq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
